// File: rtl/sub_chunk_seq32.sv
// sub_chunk_seq32: multi-cycle 32-bit subtract-with-borrow.
// Computes op1 - op2 - bin one CHUNK-bit slice per clock, from LSB to MSB,
// and carries the borrow between slices in a register. Results and flags
// are published only on the final slice edge, so partial sums never leak.
module sub_chunk_seq32 #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        bin,
  output logic        ready,
  output logic        valid,
  output logic [31:0] diff,
  output logic        bout,
  output logic        zero,
  output logic        ovf
);

  localparam int         N      = 32 / CHUNK;
  localparam logic [4:0] K_LAST = 5'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        borrow_q, borrow_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] diff_q, diff_d;
  logic        bout_q, bout_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;

  // Slice datapath signals.
  logic [31:0]    sh;
  logic [31:0]    a_sh;
  logic [31:0]    b_sh;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK:0]   slice_res;
  logic [31:0]    slice_mask;
  logic [31:0]    acc_new;

  // Subtract the current slice and merge it into the working difference.
  always_comb begin
    sh         = 32'(k_q) * 32'(CHUNK);
    a_sh       = a_q >> sh;
    b_sh       = b_q >> sh;
    slice_a    = a_sh[CHUNK-1:0];
    slice_b    = b_sh[CHUNK-1:0];
    slice_res  = {1'b0, slice_a} - {1'b0, slice_b} - {{CHUNK{1'b0}}, borrow_q};
    slice_mask = 32'({CHUNK{1'b1}}) << sh;
    acc_new    = (acc_q & ~slice_mask) | ((32'(slice_res[CHUNK-1:0])) << sh);
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = op1;
          b_d      = op2;
          borrow_d = bin;
          k_d      = 5'd0;
          acc_d    = 32'd0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_new;
        borrow_d = slice_res[CHUNK];
        if (k_q == K_LAST) begin
          k_d     = 5'd0;
          diff_d  = acc_new;
          bout_d  = slice_res[CHUNK];
          zero_d  = (acc_new == 32'd0);
          ovf_d   = (a_q[31] != b_q[31]) && (acc_new[31] != a_q[31]);
          state_d = S_DONE;
        end else begin
          k_d = 5'(k_q + 5'd1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      // NOTE: the working registers are plain flops, not a memory, so they
      // are cleared along with the control state for a clean restart.
      state_q  <= S_IDLE;
      k_q      <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      borrow_q <= 1'b0;
      acc_q    <= 32'd0;
      diff_q   <= 32'd0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign valid = (state_q == S_DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;
  assign zero  = zero_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_sub_chunk_seq32.sv
// Bench for sub_chunk_seq32: three instances (CHUNK = 1, 8, 32) share the
// stimulus; a cycle-level behavioural model predicts every output of each.
module tb_sub_chunk_seq32;

  localparam int NI = 3;
  localparam int CHS [NI] = '{1, 8, 32};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        bin = 1'b0;

  logic        ready_w [NI];
  logic        valid_w [NI];
  logic [31:0] diff_w  [NI];
  logic        bout_w  [NI];
  logic        zero_w  [NI];
  logic        ovf_w   [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    sub_chunk_seq32 #(.CHUNK(CHS[gi])) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .op1  (op1),
      .op2  (op2),
      .bin  (bin),
      .ready(ready_w[gi]),
      .valid(valid_w[gi]),
      .diff (diff_w[gi]),
      .bout (bout_w[gi]),
      .zero (zero_w[gi]),
      .ovf  (ovf_w[gi])
    );
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: an operation accepted at edge e produces its result
  // at edge e+N, valid for one cycle, and the unit is ready again at e+N+1.
  logic        m_ready [NI];
  logic        m_valid [NI];
  logic [31:0] m_diff  [NI];
  logic        m_bout  [NI];
  logic        m_zero  [NI];
  logic        m_ovf   [NI];
  logic [31:0] p_diff  [NI];
  logic        p_bout  [NI];
  logic        p_zero  [NI];
  logic        p_ovf   [NI];
  int          done_edge [NI];
  int          ecount = 0;

  always @(posedge clk) begin
    logic [32:0] full;
    ecount++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_ready[i] = 1'b1;
        m_valid[i] = 1'b0;
        m_diff[i]  = 32'd0;
        m_bout[i]  = 1'b0;
        m_zero[i]  = 1'b0;
        m_ovf[i]   = 1'b0;
      end else if (m_ready[i]) begin
        m_valid[i] = 1'b0;
        if (start) begin
          full         = {1'b0, op1} - {1'b0, op2} - 33'(bin);
          p_diff[i]    = full[31:0];
          p_bout[i]    = ({1'b0, op1} < ({1'b0, op2} + 33'(bin)));
          p_zero[i]    = (full[31:0] == 32'd0);
          p_ovf[i]     = (op1[31] != op2[31]) && (full[31] != op1[31]);
          done_edge[i] = ecount + 32 / CHS[i];
          m_ready[i]   = 1'b0;
        end
      end else if (ecount == done_edge[i]) begin
        m_diff[i]  = p_diff[i];
        m_bout[i]  = p_bout[i];
        m_zero[i]  = p_zero[i];
        m_ovf[i]   = p_ovf[i];
        m_valid[i] = 1'b1;
      end else if (ecount == done_edge[i] + 1) begin
        m_valid[i] = 1'b0;
        m_ready[i] = 1'b1;
      end
    end
  end

  // Compare process: every output of every instance on every falling edge.
  logic chk_en = 1'b0;
  int   vcnt [NI] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (valid_w[i] === 1'b1) vcnt[i]++;
      if (chk_en) begin
        check($sformatf("c%0d_ready", CHS[i]), 32'(ready_w[i]), 32'(m_ready[i]));
        check($sformatf("c%0d_valid", CHS[i]), 32'(valid_w[i]), 32'(m_valid[i]));
        check($sformatf("c%0d_diff",  CHS[i]), diff_w[i],       m_diff[i]);
        check($sformatf("c%0d_bout",  CHS[i]), 32'(bout_w[i]),  32'(m_bout[i]));
        check($sformatf("c%0d_zero",  CHS[i]), 32'(zero_w[i]),  32'(m_zero[i]));
        check($sformatf("c%0d_ovf",   CHS[i]), 32'(ovf_w[i]),   32'(m_ovf[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_all_idle();
    int n = 0;
    while (!(m_ready[0] && m_ready[1] && m_ready[2]) && n < 100) begin
      step();
      n++;
    end
    check("idle_wait_timeout", 32'(n >= 100), 32'd0);
  endtask

  // Hand-computed expectations, checked on every instance after completion.
  task automatic expect_lit(input string nm, input logic [31:0] d, input logic b,
                            input logic z, input logic o);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_c%0d_diff", nm, CHS[i]), diff_w[i],      d);
      check($sformatf("%s_c%0d_bout", nm, CHS[i]), 32'(bout_w[i]), 32'(b));
      check($sformatf("%s_c%0d_zero", nm, CHS[i]), 32'(zero_w[i]), 32'(z));
      check($sformatf("%s_c%0d_ovf",  nm, CHS[i]), 32'(ovf_w[i]),  32'(o));
    end
  endtask

  // One operation; operands are scrambled after the accepting edge, and
  // optionally a conflicting start is pulsed while the operation runs.
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic bi, input logic intrude);
    int v0 [NI];
    wait_all_idle();
    for (int i = 0; i < NI; i++) v0[i] = vcnt[i];
    op1 = a; op2 = b; bin = bi; start = 1'b1;
    step();
    op1 = $urandom; op2 = $urandom; bin = 1'($urandom);
    start = intrude;
    step();
    start = 1'b0;
    repeat (40) step();
    for (int i = 0; i < NI; i++)
      check($sformatf("%s_c%0d_valid_pulses", nm, CHS[i]), 32'(vcnt[i] - v0[i]), 32'd1);
  endtask

  initial begin
    int v0 [NI];
    repeat (3) step();
    rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_c%0d_ready", CHS[i]), 32'(ready_w[i]), 32'd1);
      check($sformatf("rst_c%0d_valid", CHS[i]), 32'(valid_w[i]), 32'd0);
    end
    expect_lit("rst", 32'h0, 1'b0, 1'b0, 1'b0);

    do_op("zero_minus_one", 32'h0, 32'h1, 1'b0, 1'b0);
    expect_lit("zero_minus_one", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op("min_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    expect_lit("min_neg", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    do_op("mixed", 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0);
    expect_lit("mixed", 32'h0001_FFFF, 1'b1, 1'b0, 1'b0);
    do_op("ripple", 32'h0, 32'h0, 1'b1, 1'b0);
    expect_lit("ripple", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op("equal", 32'h5, 32'h5, 1'b0, 1'b0);
    expect_lit("equal", 32'h0, 1'b0, 1'b1, 1'b0);
    do_op("intrude", 32'h1234_5678, 32'h0000_0076, 1'b1, 1'b1);
    expect_lit("intrude", 32'h1234_5601, 1'b0, 1'b0, 1'b0);

    // Reset on the edge that would process slice 2.
    wait_all_idle();
    op1 = 32'hDEAD_BEEF; op2 = 32'h0123_4567; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("midrst_c%0d_ready", CHS[i]), 32'(ready_w[i]), 32'd1);
      check($sformatf("midrst_c%0d_valid", CHS[i]), 32'(valid_w[i]), 32'd0);
      v0[i] = vcnt[i];
    end
    expect_lit("midrst", 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (40) step();
    for (int i = 0; i < NI; i++)
      check($sformatf("midrst_c%0d_no_valid", CHS[i]), 32'(vcnt[i] - v0[i]), 32'd0);

    // Random phase: start held high, operands change every cycle.
    for (int i = 0; i < NI; i++) v0[i] = vcnt[i];
    start = 1'b1;
    for (int c = 0; c < 34100; c++) begin
      op1 = $urandom;
      op2 = ($urandom_range(0, 7) == 0) ? op1 : $urandom;
      bin = 1'($urandom);
      step();
    end
    start = 1'b0;
    repeat (40) step();
    check("random_c1_ops_ge_1000", 32'((vcnt[0] - v0[0]) >= 1000), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_chunk_seq32.md
# sub_chunk_seq32

Multi-cycle 32-bit subtractor: the subtract-with-borrow counterpart of the 32-bit lookahead adder. It computes op1 − op2 − bin one CHUNK-bit slice per clock, from LSB to MSB, and carries the borrow between slices in a register. A start/ready/valid handshake lets the datapath controller issue operations. It is the area-lean path for sequential arithmetic in the ALU alongside the single-cycle adder.

## Interface
- CHUNK, default 8: bits processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 (must divide 32). Derived N = 32/CHUNK.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted only on a clk edge where ready=1.
- op1  in  32  minuend. Sampled on the accepting edge only.
- op2  in  32  subtrahend. Sampled on the accepting edge only.
- bin  in  1  borrow-in. Sampled on the accepting edge only.
- ready  out  1  high only in IDLE.
- valid  out  1  one-cycle pulse marking a completed result.
- diff  out  32  (op1 − op2 − bin) mod 2^32.
- bout  out  1  borrow-out. 1 iff op1 < op2 + bin (unsigned).
- zero  out  1  diff == 0.
- ovf  out  1  signed overflow: op1[31]≠op2[31] && diff[31]≠op1[31].

## Operation
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - When start=1: latch op1, op2 and bin into working registers, set borrow=bin, set slice counter k=0, go to RUN.
- RUN, once per edge:
  - {b, d} = op1[k] − op2[k] − borrow, where [k] is bits k*CHUNK+CHUNK−1 : k*CHUNK and b is the borrow out of the slice.
  - Write d into slice k of the working diff register. Set borrow=b. Increment k.
  - On the edge that processes slice N−1: load diff, bout, zero and ovf from the final working values, then go to DONE.
- DONE: valid=1 for exactly one cycle, then IDLE unconditionally.
- Input handling:
  - start is ignored when ready=0. No queuing and no error flag.
  - Changes on op1, op2 and bin after the accepting edge have no effect on the operation in flight.
- Output registers:
  - diff, bout, zero and ovf change only on the final RUN edge.
  - They hold that value through DONE and IDLE until the next operation completes. Partial results are never visible.
- Reset:
  - At any time, rst=1 forces IDLE.
  - ready=1, valid=0, diff=0, bout=0, zero=0, ovf=0. Working registers and k are cleared.
  - An in-flight operation is aborted and produces no valid.
- Reset dominates start on the same edge. An operation is never accepted while rst=1.

## Timing
- Accepting edge E0. Slice edges E1..EN; valid is high in the cycle after EN. Return to IDLE at EN+1.
- ready is low from after E0 until after EN+1. Issue interval is N+2 cycles: 6 cycles for CHUNK=8, 34 cycles for CHUNK=1.
- CHUNK=32 degenerates to a single RUN cycle. The same state sequence still applies.
- start held high continuously is accepted at every IDLE cycle, giving back-to-back operations at N+2 cadence.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset, then op1=0, op2=1, bin=0, start -> after N+1 cycles valid pulses with diff=FFFFFFFF, bout=1, zero=0, ovf=0. ready returns high.
- op1=80000000, op2=00000001, bin=0 -> diff=7FFFFFFF, bout=0, ovf=1. Then op1=0000FFFF, op2=FFFF0000, bin=0 -> diff=0001FFFF, bout=1, ovf=0.
- Full borrow ripple: op1=0, op2=0, bin=1 -> diff=FFFFFFFF, bout=1. op1=5, op2=5, bin=0 -> diff=0, zero=1, bout=0.
- Handshake:
  - Pulse start with different operands during RUN -> ignored. The result matches the first operands.
  - Operand changes after E0 -> no effect.
  - valid is exactly 1 cycle wide.
- Reset mid-RUN at slice 2 -> next cycle ready=1, all outputs 0, and no valid pulse follows.
- Repeat all of the above with CHUNK=1 and CHUNK=32. Check latency N+1 to valid, and results identical to a reference model of (op1 − op2 − bin) with flags, over 1000 random vectors.
